// File: rtl/apb_bridge_nslv_pkg.sv
// apb_bridge_nslv_pkg: shared encodings and strobe generation for the AHB-to-APB bridge
package apb_bridge_nslv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SETUP,
      ST_ACCESS,
      ST_ERR1,
      ST_ERR2
   } state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   function automatic logic [3:0] pstrb_f(input logic [2:0] size, input logic [1:0] a);
      return size == HSIZE_BYTE ? 4'b0001 << a :
             size == HSIZE_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
   endfunction

endpackage

// File: rtl/apb_pclken_div.sv
// apb_pclken_div: free-running HCLK divider producing a one-cycle PCLKEN pulse every PCLK_DIV cycles
module apb_pclken_div #(
   parameter int PCLK_DIV = 1
) (
   input  logic HCLK,
   input  logic HRESETn,
   output logic PCLKEN
);

   localparam int CW = PCLK_DIV > 1 ? $clog2(PCLK_DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign PCLKEN = cnt_q == CW'(PCLK_DIV - 1);
   assign cnt_d  = PCLKEN ? '0 : cnt_q + 1'b1;

   always_ff @(posedge HCLK) cnt_q <= !HRESETn ? '0 : cnt_d;

endmodule

// File: rtl/apb_bridge_nslv.sv
// apb_bridge_nslv: AHB-Lite slave to multi-slave APB3/APB4 master with clock-enable ratio and PREADY timeout
module apb_bridge_nslv #(
   parameter int NSLV     = 10,
   parameter int IDX_W    = 4,
   parameter int SLV_AW   = 16,
   parameter int PCLK_DIV = 1,
   parameter int TMO_CYC  = 256
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 HSEL,
   input  logic [31:0]          HADDR,
   input  logic [1:0]           HTRANS,
   input  logic                 HWRITE,
   input  logic [2:0]           HSIZE,
   input  logic [31:0]          HWDATA,
   input  logic                 HREADY,
   output logic                 HREADYOUT,
   output logic                 HRESP,
   output logic [31:0]          HRDATA,
   output logic                 PCLKEN,
   output logic [NSLV-1:0]      PSEL,
   output logic                 PENABLE,
   output logic [31:0]          PADDR,
   output logic                 PWRITE,
   output logic [31:0]          PWDATA,
   output logic [3:0]           PSTRB,
   input  logic [32*NSLV-1:0]   PRDATA,
   input  logic [NSLV-1:0]      PREADY,
   input  logic [NSLV-1:0]      PSLVERR
);

   import apb_bridge_nslv_pkg::*;

   localparam int TW = $clog2(TMO_CYC);

   state_e        state_q;
   logic [31:0]   addr_q;
   logic          write_q;
   logic [2:0]    size_q;
   logic [TW-1:0] tmo_q;
   logic [IDX_W:0] idx;
   logic [31:0]   prdata_sel;
   logic          capture, bad_idx, sel_ready, sel_err;

   apb_pclken_div #(.PCLK_DIV(PCLK_DIV)) u_div (
      .HCLK    (HCLK),
      .HRESETn (HRESETn),
      .PCLKEN  (PCLKEN)
   );

   assign capture   = HSEL & HREADY & (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
   assign idx       = {1'b0, addr_q[SLV_AW+IDX_W-1:SLV_AW]};
   assign bad_idx   = idx >= (IDX_W+1)'(NSLV);
   // PSEL is one-hot during SETUP/ACCESS, so masking with it selects the addressed slave
   assign sel_ready = |(PREADY & PSEL);
   assign sel_err   = |(PSLVERR & PSEL);

   always_comb begin
      prdata_sel = '0;
      for (int i = 0; i < NSLV; i++) prdata_sel |= PSEL[i] ? PRDATA[32*i +: 32] : 32'h0;
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q   <= ST_IDLE;
         HREADYOUT <= 1'b1;
         HRESP     <= HRESP_OKAY;
         HRDATA    <= '0;
         PSEL      <= '0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= '0;
         PSTRB     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         size_q    <= '0;
         tmo_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_ERR2: begin
               HRESP     <= HRESP_OKAY;
               HREADYOUT <= !capture;
               state_q   <= capture ? ST_WAIT : ST_IDLE;
               if (capture) begin
                  addr_q  <= HADDR;
                  write_q <= HWRITE;
                  size_q  <= HSIZE;
               end
            end
            ST_WAIT: if (PCLKEN) begin
               if (bad_idx) begin
                  state_q <= ST_ERR1;
                  HRESP   <= HRESP_ERROR;
                  HRDATA  <= '0;
               end else begin
                  state_q <= ST_SETUP;
                  PSEL    <= NSLV'(1) << idx;
                  PADDR   <= addr_q;
                  PWRITE  <= write_q;
                  PWDATA  <= HWDATA;
                  PSTRB   <= write_q ? pstrb_f(size_q, addr_q[1:0]) : 4'h0;
               end
            end
            ST_SETUP: if (PCLKEN) begin
               state_q <= ST_ACCESS;
               PENABLE <= 1'b1;
               tmo_q   <= '0;
            end
            ST_ACCESS: if (PCLKEN) begin
               if (sel_ready || tmo_q == TW'(TMO_CYC - 1)) begin
                  PSEL    <= '0;
                  PENABLE <= 1'b0;
               end
               if (sel_ready && !sel_err) begin
                  state_q   <= ST_IDLE;
                  HRDATA    <= write_q ? 32'h0 : prdata_sel;
                  HREADYOUT <= 1'b1;
               end else if (sel_ready || tmo_q == TW'(TMO_CYC - 1)) begin
                  state_q <= ST_ERR1;
                  HRESP   <= HRESP_ERROR;
                  HRDATA  <= '0;
               end else begin
                  tmo_q <= tmo_q + 1'b1;
               end
            end
            ST_ERR1: begin
               state_q   <= ST_ERR2;
               HREADYOUT <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_bridge_nslv.sv
// tb_apb_bridge_nslv: directed scoreboard bench for the bridge at PCLK_DIV=1 and PCLK_DIV=4
module tb_apb_bridge_nslv;

   localparam int NSLV = 10;
   localparam int TMO  = 16;

   typedef struct {
      logic            err;
      logic [31:0]     rdata;
      logic [NSLV-1:0] psel;
      logic [3:0]      pstrb;
      int              waits;
      int              acc;
   } exp_t;

   logic HCLK = 1'b0;
   logic HRESETn, HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA;
   logic [1:0] HTRANS;
   logic [2:0] HSIZE;
   logic [32*NSLV-1:0] PRDATA;
   logic [NSLV-1:0] PREADY, PSLVERR;

   logic hreadyout, hresp, pclken, penable, pwrite;
   logic [31:0] hrdata, paddr, pwdata;
   logic [NSLV-1:0] psel;
   logic [3:0] pstrb;

   logic hreadyout4, hresp4, pclken4, penable4, pwrite4;
   logic [31:0] hrdata4, paddr4, pwdata4;
   logic [NSLV-1:0] psel4;
   logic [3:0] pstrb4;

   int n_chk = 0;
   int n_fail = 0;
   exp_t sb_q[$];

   always #5 HCLK = ~HCLK;

   apb_bridge_nslv #(.NSLV(NSLV), .IDX_W(4), .SLV_AW(16), .PCLK_DIV(1), .TMO_CYC(TMO)) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata), .PCLKEN(pclken),
      .PSEL(psel), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite), .PWDATA(pwdata),
      .PSTRB(pstrb), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   apb_bridge_nslv #(.NSLV(NSLV), .IDX_W(4), .SLV_AW(16), .PCLK_DIV(4), .TMO_CYC(TMO)) u_dut4 (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(hreadyout4), .HRESP(hresp4), .HRDATA(hrdata4), .PCLKEN(pclken4),
      .PSEL(psel4), .PENABLE(penable4), .PADDR(paddr4), .PWRITE(pwrite4), .PWDATA(pwdata4),
      .PSTRB(pstrb4), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   function automatic exp_t model(input logic [31:0] a, input logic w, input logic [2:0] sz,
                                  input int lowcyc, input logic err, input logic [31:0] rd);
      exp_t e;
      int idx;
      logic bad, tmo;
      idx = int'(a[19:16]);
      bad = idx >= NSLV;
      tmo = !bad && lowcyc >= TMO;
      e.err = bad || tmo || err;
      e.psel = bad ? '0 : NSLV'(1) << idx;
      e.waits = bad ? 2 : tmo ? 3 + TMO : 3 + lowcyc + (err ? 1 : 0);
      e.acc = bad ? 0 : tmo ? TMO : lowcyc + 1;
      e.rdata = (e.err || w) ? 32'h0 : rd;
      case (sz)
         3'd0:    e.pstrb = {a[1:0] == 2'd3, a[1:0] == 2'd2, a[1:0] == 2'd1, a[1:0] == 2'd0};
         3'd1:    e.pstrb = a[1] ? 4'b1100 : 4'b0011;
         default: e.pstrb = 4'b1111;
      endcase
      if (!w) e.pstrb = 4'h0;
      return e;
   endfunction

   task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd,
                       input int lowcyc, input logic err, input logic [31:0] rd);
      exp_t e;
      int idx, low, acc;
      logic seen, seen_en, last_resp, r_pwrite;
      logic [NSLV-1:0] mask, r_psel;
      logic [31:0] r_paddr, r_pwdata;
      logic [3:0] r_pstrb;
      idx = int'(a[19:16]);
      mask = idx < NSLV ? NSLV'(1) << idx : '0;
      for (int i = 0; i < NSLV; i++) PRDATA[32*i +: 32] = (i == idx) ? rd : ~rd ^ 32'(i);
      PREADY = '0;
      PSLVERR = err ? mask : '0;
      sb_q.push_back(model(a, w, sz, lowcyc, err, rd));
      HSEL = 1'b1; HTRANS = 2'd2; HADDR = a; HWRITE = w; HSIZE = sz;
      tick();
      HSEL = 1'b0; HTRANS = 2'd0; HWDATA = wd;
      low = 0; acc = 0; seen = 0; seen_en = 0; last_resp = 0; r_pwrite = 0;
      r_psel = '0; r_paddr = '0; r_pwdata = '0; r_pstrb = '0;
      while (!hreadyout && low < 60) begin
         low++;
         last_resp = hresp;
         if (!seen && psel != '0) begin
            seen = 1; r_psel = psel; r_paddr = paddr; r_pwrite = pwrite; r_pwdata = pwdata; r_pstrb = pstrb;
            chk("setup_penable", penable, 1'b0);
         end else if (seen && !seen_en && psel != '0) begin
            seen_en = 1;
            chk("access_penable", penable, 1'b1);
         end
         if (penable) acc++;
         PREADY = (penable && acc > lowcyc) ? mask : '0;
         tick();
      end
      e = sb_q.pop_front();
      chk("wait_states", low, e.waits);
      chk("access_cycles", acc, e.acc);
      chk("err1_hresp", last_resp, e.err);
      chk("hresp", hresp, e.err);
      chk("hrdata", hrdata, e.rdata);
      chk("psel", r_psel, e.psel);
      if (seen) begin
         chk("paddr", r_paddr, a);
         chk("pwrite", r_pwrite, w);
         chk("pstrb", r_pstrb, e.pstrb);
         if (w) chk("pwdata", r_pwdata, wd);
      end
      PREADY = '0;
      PSLVERR = '0;
      tick();
      chk("idle_ready", hreadyout, 1'b1);
      chk("idle_resp", hresp, 1'b0);
   endtask

   initial begin
      logic prv_clk, prv_en;
      logic [NSLV-1:0] prv_sel;
      int low;
      HRESETn = 0; HSEL = 0; HADDR = '0; HTRANS = 2'd0; HWRITE = 0; HSIZE = 3'd2;
      HWDATA = '0; HREADY = 1; PRDATA = '0; PREADY = '0; PSLVERR = '0;
      tick(); tick();
      chk("rst_hreadyout", hreadyout, 1'b1);
      chk("rst_hresp", hresp, 1'b0);
      chk("rst_hrdata", hrdata, 32'h0);
      chk("rst_psel", psel, '0);
      chk("rst_penable", penable, 1'b0);
      chk("rst_paddr", paddr, 32'h0);
      chk("rst_pwrite", pwrite, 1'b0);
      chk("rst_pwdata", pwdata, 32'h0);
      chk("rst_pstrb", pstrb, 4'h0);
      chk("rst_pclken", pclken, 1'b1);
      HRESETn = 1;

      // selected but non-capturing cycles must stay zero-wait OKAY
      HSEL = 1; HADDR = 32'h0002_0000; HTRANS = 2'd0; tick();
      chk("htrans_idle_ready", hreadyout, 1'b1);
      HTRANS = 2'd1; tick();
      chk("htrans_busy_ready", hreadyout, 1'b1);
      HTRANS = 2'd2; HREADY = 0; tick();
      chk("hready_low_ready", hreadyout, 1'b1);
      chk("hready_low_psel", psel, '0);
      HSEL = 0; HTRANS = 2'd0; HREADY = 1; tick();

      xfer(32'h0002_0010, 1, 3'd2, 32'hDEAD_BEEF, 0, 0, 32'h0);
      xfer(32'h0003_0002, 1, 3'd0, 32'h1111_2222, 0, 0, 32'h0);
      xfer(32'h0003_0002, 1, 3'd1, 32'h3333_4444, 0, 0, 32'h0);
      xfer(32'h0000_0003, 1, 3'd0, 32'h5555_6666, 0, 0, 32'h0);
      xfer(32'h0003_0000, 0, 3'd2, 32'h0, 0, 0, 32'hA5A5_0F0F);
      xfer(32'h0005_0000, 0, 3'd2, 32'h0, 3, 0, 32'h1234_5678);
      xfer(32'h0001_0000, 1, 3'd2, 32'h7777_8888, 0, 1, 32'h0);
      xfer(32'h000C_0000, 0, 3'd2, 32'h0, 0, 0, 32'h9999_AAAA);
      xfer(32'h0009_0000, 0, 3'd2, 32'h0, 100, 0, 32'hBBBB_CCCC);
      xfer(32'h0009_0004, 0, 3'd2, 32'h0, 1, 0, 32'hFEED_0001);

      // PCLK_DIV=4 instance: PCLKEN cadence, APB outputs only move on APB edges
      HRESETn = 0; tick();
      chk("rst4_hreadyout", hreadyout4, 1'b1);
      chk("rst4_psel", psel4, '0);
      HRESETn = 1;
      for (int k = 0; k < 8; k++) begin
         chk("pclken4_cadence", pclken4, k % 4 == 3);
         tick();
      end
      for (int i = 0; i < NSLV; i++) PRDATA[32*i +: 32] = (i == 7) ? 32'hCAFE_F00D : 32'h0BAD_0000 + 32'(i);
      HSEL = 1; HTRANS = 2'd2; HADDR = 32'h0007_0004; HWRITE = 0; HSIZE = 3'd2;
      prv_clk = pclken4; prv_sel = psel4; prv_en = penable4;
      tick();
      HSEL = 0; HTRANS = 2'd0;
      low = 0;
      while (!hreadyout4 && low < 80) begin
         low++;
         if (psel4 !== prv_sel || penable4 !== prv_en) chk("apb_edge4", prv_clk, 1'b1);
         PREADY = penable4 ? NSLV'(1) << 7 : '0;
         prv_clk = pclken4; prv_sel = psel4; prv_en = penable4;
         tick();
      end
      chk("apb_edge4_end", prv_clk, 1'b1);
      chk("wait_states4", low, 11);
      chk("hrdata4", hrdata4, 32'hCAFE_F00D);
      chk("hresp4", hresp4, 1'b0);
      chk("psel4_done", psel4, '0);
      PREADY = '0;

      // reset in the middle of an ACCESS phase
      HSEL = 1; HTRANS = 2'd2; HADDR = 32'h0002_0000; HWRITE = 1; HSIZE = 3'd2;
      tick();
      HSEL = 0; HTRANS = 2'd0; HWDATA = 32'h0123_4567;
      for (int c = 0; c < 40 && !penable4; c++) tick();
      chk("access4_reached", penable4, 1'b1);
      HRESETn = 0; tick();
      chk("rst_mid_psel", psel4, '0);
      chk("rst_mid_penable", penable4, 1'b0);
      chk("rst_mid_hreadyout", hreadyout4, 1'b1);
      chk("rst_mid_hrdata", hrdata4, 32'h0);
      chk("rst_mid_pclken", pclken4, 1'b0);
      HRESETn = 1;
      for (int k = 0; k < 4; k++) begin
         chk("pclken4_restart", pclken4, k == 3);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/apb_bridge_nslv.md
Name: apb_bridge_nslv

Overview:
Parametrised AHB-Lite slave to APB master bridge; successor to the fixed bridge inside the north-bridge. Supports a configurable slave count with one PSEL per slave, an integer PCLK enable ratio, APB3/APB4 signalling (PSLVERR, PSTRB), and a PREADY timeout. The bridge converts any APB error into a two-cycle AHB ERROR response. It sits between the AHB bus matrix and the APB south-bridge peripherals.

Parameters:
NSLV, 10, number of APB slaves (1..16).
IDX_W, 4, address bits used for slave index; NSLV <= 2**IDX_W.
SLV_AW, 16, address bits per slave region; index = HADDR[SLV_AW+IDX_W-1:SLV_AW].
PCLK_DIV, 1, HCLK cycles per APB cycle (>=1).
TMO_CYC, 256, APB ACCESS cycles before timeout (>=2).

Ports:
HCLK  in  1  single clock.
HRESETn  in  1  synchronous, active-low reset, sampled on the HCLK rising edge.
HSEL  in  1  bridge selected.
HADDR  in  32  AHB address.
HTRANS  in  2  AHB transfer type.
HWRITE  in  1  write.
HSIZE  in  3  0=byte, 1=half, 2=word.
HWDATA  in  32  write data.
HREADY  in  1  bus-wide ready.
HREADYOUT  out  1  bridge ready.
HRESP  out  1  1=ERROR.
HRDATA  out  32  read data.
PCLKEN  out  1  APB clock-enable pulse.
PSEL  out  NSLV  one-hot slave select.
PENABLE  out  1  APB access phase.
PADDR  out  32  APB address.
PWRITE  out  1  APB direction.
PWDATA  out  32  APB write data.
PSTRB  out  4  byte strobes.
PRDATA  in  32*NSLV  read data; slave i occupies bits [32i+31:32i].
PREADY  in  NSLV  per-slave ready.
PSLVERR  in  NSLV  per-slave error.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, PSTRB=0, divider=0, state IDLE. Reset asserted mid-transfer aborts the transfer; the next cycle shows reset values.
- PCLKEN: divider counts 0..PCLK_DIV-1 continuously; PCLKEN=1 when count==PCLK_DIV-1. With PCLK_DIV=1, PCLKEN is constantly 1.
- "APB edge" means an HCLK rising edge with PCLKEN=1. All APB outputs and APB state transitions occur only on APB edges; exceptions: IDLE->WAIT and ERR1->ERR2->IDLE.
- Capture condition: HSEL & HTRANS[1] & HREADY. On capture, latch HADDR, HWRITE, HSIZE; set HREADYOUT=0. HTRANS IDLE or BUSY gets a zero-wait OKAY.
- States:
  - IDLE: on capture -> WAIT.
  - WAIT: latch HWDATA every cycle. At an APB edge:
    - If index >= NSLV -> ERR1, no PSEL asserted.
    - Otherwise -> SETUP with PSEL[idx]=1, PENABLE=0, and PADDR/PWRITE/PWDATA/PSTRB driven.
  - SETUP: at an APB edge -> ACCESS, PENABLE=1; timeout counter cleared.
  - ACCESS: sampled at each APB edge.
    - PREADY[idx]=1 and PSLVERR[idx]=0: PSEL=0, PENABLE=0, HRDATA=PRDATA[idx] (reads) or 0 (writes), HREADYOUT=1 -> IDLE.
    - PREADY[idx]=1 and PSLVERR[idx]=1: PSEL=0, PENABLE=0 -> ERR1.
    - PREADY[idx]=0: counter increments; when counter reaches TMO_CYC-1, PSEL=0, PENABLE=0 -> ERR1.
  - ERR1: HRESP=1, HREADYOUT=0, HRDATA=0 -> ERR2 (next HCLK cycle).
  - ERR2: HRESP=1, HREADYOUT=1 -> IDLE. A capture in ERR2 is legal and proceeds to WAIT.
- PSTRB for writes:
  - Word: 4'b1111.
  - Half: 4'b0011 << (2*HADDR[1]).
  - Byte: 4'b0001 << HADDR[1:0].
  - Reads: PSTRB=0.
- Latency at PCLK_DIV=1 with a zero-wait slave: capture at cycle t, HREADYOUT returns to 1 at t+4 (3 AHB wait states). Each PREADY-low cycle adds PCLK_DIV HCLK cycles.
- PADDR = latched HADDR, unmodified.

Decomposition:
- Shared package/header holds:
  - state encoding (IDLE, WAIT, SETUP, ACCESS, ERR1, ERR2);
  - HTRANS constants (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - HRESP OKAY/ERROR;
  - HSIZE codes;
  - the PSTRB generation function.
- One sub-module: apb_pclken_div (parameter PCLK_DIV; ports HCLK, HRESETn, PCLKEN).

Test Plan:
- PCLK_DIV=1, NONSEQ write 0x0002_0010, HSIZE=2, HWDATA=0xDEADBEEF, PREADY=1 -> PSEL=0x004, PADDR=0x0002_0010, PSTRB=4'hF, PWDATA=0xDEADBEEF; PENABLE one cycle after PSEL; HREADYOUT low 3 cycles; HRESP=0.
- Byte write at 0x0003_0002 -> PSTRB=4'b0100. Halfword write at 0x0003_0002 -> PSTRB=4'b1100. Read -> PSTRB=0.
- Read 0x0005_0000, PREADY[5] low for 3 ACCESS cycles, PRDATA slice 5=0x12345678 -> HRDATA=0x12345678 when HREADYOUT rises; total 6 wait states.
- PSLVERR[1]=1 with PREADY -> one cycle HRESP=1/HREADYOUT=0, then one cycle HRESP=1/HREADYOUT=1, HRDATA=0. Address 0x000C_0000 (index 12 >= NSLV) -> same two-cycle error, PSEL stays 0.
- TMO_CYC=16, PREADY stuck at 0 -> PSEL/PENABLE drop after 16 ACCESS cycles, then two-cycle ERROR.
- PCLK_DIV=4 -> PCLKEN high every 4th HCLK; PSEL/PENABLE change only on those edges. HRESETn=0 during ACCESS -> next cycle PSEL=0, PENABLE=0, HREADYOUT=1, divider restarts at 0.
